// File: rtl/tlat_bank_pkg.sv
// Shared types and limits for the tlat_bank_oe latch bank.
// Holds the OE sequencer state encoding, the configuration limits and
// the helper that sizes the per-channel turn-on delay counter.
package tlat_bank_pkg;

  localparam int MAX_WIDTH    = 64;
  localparam int MAX_CHANNELS = 16;
  localparam int MAX_OE_DELAY = 255;

  typedef enum logic [1:0] {
    OE_OFF = 2'd0,
    OE_ARM = 2'd1,
    OE_ON  = 2'd2
  } oe_state_t;

  // Counter width for a turn-on delay. A zero delay still gets one bit,
  // so the counter never collapses to a zero-width vector.
  function automatic int cnt_width(input int delay);
    int w;
    if (delay < 1) begin
      w = 1;
    end else begin
      w = $clog2(delay + 1);
    end
    return w;
  endfunction

endpackage : tlat_bank_pkg

// File: rtl/tlat_chan.sv
// One latch channel: the storage register, the transparent latch value,
// the break-before-make output-enable sequencer and the gated output.
// Build option TLAT_BANK_TRISTATE_EN: a disabled output floats ('z)
// instead of being driven to zero.
module tlat_chan
  import tlat_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int OE_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             g,
  input  logic             oe,
  output logic [WIDTH-1:0] t,
  output logic [WIDTH-1:0] q,
  output logic             q_en
);

  localparam int CW = cnt_width(OE_DELAY);
  // Count value on which the sequencer leaves ARM; unused when the delay is zero.
  localparam logic [CW-1:0] CNT_LAST = (OE_DELAY > 0) ? CW'(OE_DELAY - 1) : {CW{1'b0}};

  logic [WIDTH-1:0] lat_q;
  logic [WIDTH-1:0] lat_d;
  oe_state_t        state_q;
  oe_state_t        state_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;

  // Storage capture and OE sequencer next-state.
  always_comb begin
    lat_d   = lat_q;
    state_d = state_q;
    cnt_d   = cnt_q;

    if (g) begin
      lat_d = d;
    end else begin
      lat_d = lat_q;
    end

    case (state_q)
      OE_OFF: begin
        cnt_d = {CW{1'b0}};
        if (oe) begin
          if (OE_DELAY == 0) begin
            state_d = OE_ON;
          end else begin
            state_d = OE_ARM;
          end
        end else begin
          state_d = OE_OFF;
        end
      end
      OE_ARM: begin
        if (!oe) begin
          // Any drop of the request throws the partial count away.
          state_d = OE_OFF;
          cnt_d   = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
          state_d = OE_ON;
          cnt_d   = {CW{1'b0}};
        end else begin
          state_d = OE_ARM;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      OE_ON: begin
        cnt_d = {CW{1'b0}};
        if (!oe) begin
          state_d = OE_OFF;
        end else begin
          state_d = OE_ON;
        end
      end
      default: begin
        state_d = OE_OFF;
        cnt_d   = {CW{1'b0}};
      end
    endcase
  end

  // State registers; reset clears storage and forces the driver off at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_q   <= {WIDTH{1'b0}};
      state_q <= OE_OFF;
      cnt_q   <= {CW{1'b0}};
    end else begin
      lat_q   <= lat_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Latch value and drive enable. Turn-off follows oe with no clock delay.
  always_comb begin
    if (g) begin
      t = d;
    end else begin
      t = lat_q;
    end
    q_en = (state_q == OE_ON) & oe;
  end

`ifdef TLAT_BANK_TRISTATE_EN
  assign q = q_en ? t : {WIDTH{1'bz}};
`else
  assign q = q_en ? t : {WIDTH{1'b0}};
`endif

endmodule : tlat_chan

// File: rtl/tlat_bank_oe.sv
// Bank of CHANNELS independent latch channels with break-before-make
// output enables, plus a bank-wide snapshot register.
// Build option TLAT_BANK_TRISTATE_EN: disabled channel outputs float ('z).
module tlat_bank_oe
  import tlat_bank_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int OE_DELAY = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       g,
  input  logic [CHANNELS-1:0]       oe,
  input  logic                      snap,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       q_en,
  output logic [CHANNELS*WIDTH-1:0] snap_q,
  output logic                      snap_valid
);

  if ((WIDTH < 1) || (WIDTH > MAX_WIDTH) ||
      (CHANNELS < 1) || (CHANNELS > MAX_CHANNELS) ||
      (OE_DELAY < 0) || (OE_DELAY > MAX_OE_DELAY)) begin : g_bad_cfg
    $error("tlat_bank_oe: parameter out of range");
  end

  logic [CHANNELS*WIDTH-1:0] t_all_s;
  logic [CHANNELS*WIDTH-1:0] snap_q_q;
  logic [CHANNELS*WIDTH-1:0] snap_q_d;
  logic                      snap_valid_q;
  logic                      snap_valid_d;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    tlat_chan #(
      .WIDTH    (WIDTH),
      .OE_DELAY (OE_DELAY)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (d[c*WIDTH +: WIDTH]),
      .g     (g[c]),
      .oe    (oe[c]),
      .t     (t_all_s[c*WIDTH +: WIDTH]),
      .q     (q[c*WIDTH +: WIDTH]),
      .q_en  (q_en[c])
    );
  end

  // Snapshot takes the latch values, independent of the output enables.
  always_comb begin
    if (snap) begin
      snap_q_d = t_all_s;
    end else begin
      snap_q_d = snap_q_q;
    end
    snap_valid_d = snap;
  end

  // Snapshot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q_q     <= {(CHANNELS*WIDTH){1'b0}};
      snap_valid_q <= 1'b0;
    end else begin
      snap_q_q     <= snap_q_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign snap_q     = snap_q_q;
  assign snap_valid = snap_valid_q;

endmodule : tlat_bank_oe

// File: tb/tb_tlat_bank_oe.sv
// Directed bench for tlat_bank_oe: a cycle table for the 4x8 bank
// (OE_DELAY=2) plus hand sequences for async reset, tri-state readback
// and a single-channel OE_DELAY=0 instance.
module tb_tlat_bank_oe;

  logic        clk;
  logic        rst_n;
  logic [31:0] d;
  logic [3:0]  g;
  logic [3:0]  oe;
  logic        snap;
  logic [31:0] q;
  logic [3:0]  q_en;
  logic [31:0] snap_q;
  logic        snap_valid;

  logic [7:0]  z_d;
  logic        z_g;
  logic        z_oe;
  logic        z_snap;
  logic [7:0]  z_q;
  logic        z_q_en;
  logic [7:0]  z_snap_q;
  logic        z_snap_valid;

  int total;
  int bad;

`ifdef TLAT_BANK_TRISTATE_EN
  localparam logic [7:0] DIS8 = 8'hzz;
`else
  localparam logic [7:0] DIS8 = 8'h00;
`endif

  tlat_bank_oe #(.WIDTH(8), .CHANNELS(4), .OE_DELAY(2)) dut (
    .clk(clk), .rst_n(rst_n), .d(d), .g(g), .oe(oe), .snap(snap),
    .q(q), .q_en(q_en), .snap_q(snap_q), .snap_valid(snap_valid)
  );

  tlat_bank_oe #(.WIDTH(8), .CHANNELS(1), .OE_DELAY(0)) dut_z (
    .clk(clk), .rst_n(rst_n), .d(z_d), .g(z_g), .oe(z_oe), .snap(z_snap),
    .q(z_q), .q_en(z_q_en), .snap_q(z_snap_q), .snap_valid(z_snap_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  g;
    logic [3:0]  oe;
    logic        snap;
    logic [31:0] q;
    logic [3:0]  qen;
    logic [31:0] sq;
    logic        sv;
  } vec_t;

  vec_t vt [24];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Replace channels whose enable is low with the disabled-output value.
  function automatic logic [31:0] gate_q(input logic [31:0] qv, input logic [3:0] en);
    logic [31:0] r;
    r = qv;
    for (int c = 0; c < 4; c++) begin
      if (!en[c]) r[c*8 +: 8] = DIS8;
    end
    return r;
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    // d, g, oe, snap | q, q_en, snap_q, snap_valid
    vt[0]  = '{32'h000000A5, 4'b0001, 4'b0001, 1'b0, 32'h00000000, 4'b0000, 32'h00000000, 1'b0};
    vt[1]  = '{32'h000000A5, 4'b0001, 4'b0001, 1'b0, 32'h00000000, 4'b0000, 32'h00000000, 1'b0};
    vt[2]  = '{32'h000000A5, 4'b0001, 4'b0001, 1'b0, 32'h00000000, 4'b0000, 32'h00000000, 1'b0};
    vt[3]  = '{32'h000000A5, 4'b0001, 4'b0001, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[4]  = '{32'h0000003C, 4'b0000, 4'b0001, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[5]  = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[6]  = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[7]  = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[8]  = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000022A5, 4'b0011, 32'h00000000, 1'b0};
    vt[9]  = '{32'h0000223C, 4'b0010, 4'b0001, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[10] = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[11] = '{32'h0000223C, 4'b0010, 4'b0001, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[12] = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[13] = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[14] = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000000A5, 4'b0001, 32'h00000000, 1'b0};
    vt[15] = '{32'h0000223C, 4'b0010, 4'b0011, 1'b0, 32'h000022A5, 4'b0011, 32'h00000000, 1'b0};
    vt[16] = '{32'h44332211, 4'b1111, 4'b0011, 1'b0, 32'h00002211, 4'b0011, 32'h00000000, 1'b0};
    vt[17] = '{32'hAA33BBCC, 4'b0100, 4'b0011, 1'b1, 32'h00002211, 4'b0011, 32'h00000000, 1'b0};
    vt[18] = '{32'hAA33BBCC, 4'b0100, 4'b0011, 1'b0, 32'h00002211, 4'b0011, 32'h44332211, 1'b1};
    vt[19] = '{32'hAA33BBCC, 4'b0100, 4'b0011, 1'b1, 32'h00002211, 4'b0011, 32'h44332211, 1'b0};
    vt[20] = '{32'hAA55BBCC, 4'b0100, 4'b0011, 1'b1, 32'h00002211, 4'b0011, 32'h44332211, 1'b1};
    vt[21] = '{32'hAA66BBCC, 4'b0000, 4'b0011, 1'b0, 32'h00002211, 4'b0011, 32'h44552211, 1'b1};
    vt[22] = '{32'hAA66BBCC, 4'b0000, 4'b0011, 1'b1, 32'h00002211, 4'b0011, 32'h44552211, 1'b0};
    vt[23] = '{32'hAA66BBCC, 4'b0000, 4'b0011, 1'b0, 32'h00002211, 4'b0011, 32'h44552211, 1'b1};

    // Reset with busy inputs: outputs must stay cleared.
    rst_n = 1'b0;
    d = 32'hFFFFFFFF; g = 4'b1111; oe = 4'b1111; snap = 1'b1;
    z_d = 8'h00; z_g = 1'b0; z_oe = 1'b0; z_snap = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset q", {32'h0, q}, {32'h0, gate_q(32'h0, 4'b0000)});
    chk("reset q_en", {60'h0, q_en}, 64'h0);
    chk("reset snap_valid", {63'h0, snap_valid}, 64'h0);
    chk("reset snap_q", {32'h0, snap_q}, 64'h0);
    d = 32'h0; g = 4'b0000; oe = 4'b0000; snap = 1'b0;
    rst_n = 1'b1;

    // Cycle table: drive at the falling edge, check just after.
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      d = vt[i].d; g = vt[i].g; oe = vt[i].oe; snap = vt[i].snap;
      #1;
      chk($sformatf("row%0d q", i), {32'h0, q}, {32'h0, gate_q(vt[i].q, vt[i].qen)});
      chk($sformatf("row%0d q_en", i), {60'h0, q_en}, {60'h0, vt[i].qen});
      chk($sformatf("row%0d snap_q", i), {32'h0, snap_q}, {32'h0, vt[i].sq});
      chk($sformatf("row%0d snap_valid", i), {63'h0, snap_valid}, {63'h0, vt[i].sv});
    end

    // Disabled channels 2/3 read the disabled value; enabled ones read data.
    chk("ch3 disabled", {56'h0, q[31:24]}, {56'h0, DIS8});
    chk("ch2 disabled", {56'h0, q[23:16]}, {56'h0, DIS8});
    chk("ch0 enabled", {56'h0, q[7:0]}, 64'h11);

    // Bring ch2 up, then hit async reset between edges.
    @(negedge clk);
    d = 32'hAA77BBCC; g = 4'b0100; oe = 4'b0100;
    repeat (3) @(posedge clk);
    #1;
    chk("ch2 on q_en", {60'h0, q_en}, 64'h4);
    chk("ch2 on q", {32'h0, q}, {32'h0, gate_q(32'h00770000, 4'b0100)});
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst q_en", {60'h0, q_en}, 64'h0);
    chk("async rst q", {32'h0, q}, {32'h0, gate_q(32'h0, 4'b0000)});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post rst edge1 q_en", {60'h0, q_en}, 64'h0);
    @(posedge clk); #1;
    chk("post rst edge2 q_en", {60'h0, q_en}, 64'h0);
    @(posedge clk); #1;
    chk("post rst edge3 q_en", {60'h0, q_en}, 64'h4);
    chk("post rst q", {32'h0, q}, {32'h0, gate_q(32'h00770000, 4'b0100)});

    // Zero-delay instance: enable on the first edge, immediate turn-off.
    @(negedge clk);
    z_d = 8'h5A; z_g = 1'b1; z_oe = 1'b1;
    #1;
    chk("d0 before edge q_en", {63'h0, z_q_en}, 64'h0);
    @(posedge clk); #1;
    chk("d0 after edge q_en", {63'h0, z_q_en}, 64'h1);
    chk("d0 after edge q", {56'h0, z_q}, 64'h5A);
    @(negedge clk);
    z_oe = 1'b0;
    #1;
    chk("d0 off q_en", {63'h0, z_q_en}, 64'h0);
    chk("d0 off q", {56'h0, z_q}, {56'h0, DIS8});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tlat_bank_oe

// File: doc/tlat_bank_oe.md
Name: tlat_bank_oe

Overview:
Parametrised, clocked successor to the single-bit transparent latch with output enable.
- Provides CHANNELS independent WIDTH-bit latch channels. Each channel has its own gate and output enable.
- Each channel has a break-before-make output-enable sequencer: turn-on waits OE_DELAY cycles, turn-off is immediate.
- Provides a bank-wide snapshot register.
- Sits between datapath sources and shared output buses where several drivers are time-multiplexed.

Parameters:
WIDTH, 8, data bits per channel (1..64)
CHANNELS, 4, number of independent latch channels (1..16)
OE_DELAY, 2, cycles from oe sampled high to q_en high (0..255; 0 = enable on next edge)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
d  input  CHANNELS*WIDTH  per-channel data, channel c at bits [c*WIDTH +: WIDTH]
g  input  CHANNELS  per-channel gate; 1 = transparent/capture
oe  input  CHANNELS  per-channel output-enable request
snap  input  1  snapshot strobe, single-cycle pulse
q  output  CHANNELS*WIDTH  per-channel output, same packing as d
q_en  output  CHANNELS  per-channel drive-enable status
snap_q  output  CHANNELS*WIDTH  snapshot of all channel values
snap_valid  output  1  one-cycle pulse, snapshot updated

Behaviour:
- Reset (rst_n=0, asynchronous): lat_r=0 and OE state=OFF for every channel; cnt=0; snap_q=0; snap_valid=0. q_en and q go to 0 immediately, without waiting for a clock edge.
- Storage: on each rising edge with g[c]=1, lat_r[c] <= d[c]. With g[c]=0, lat_r[c] holds.
- Latch value (combinational): t[c] = g[c] ? d[c] : lat_r[c]. This gives zero-latency transparency; lat_r holds the last value seen while g was high.
- OE FSM per channel (states OFF, ARM, ON; cnt is $clog2(OE_DELAY+1) bits):
  - OFF: if oe[c]=1, go to ARM with cnt=0. If OE_DELAY=0, go directly to ON.
  - ARM: if oe[c]=0, go to OFF and clear cnt. Else if cnt==OE_DELAY-1, go to ON. Else cnt++.
  - ON: if oe[c]=0, go to OFF.
- q_en[c] = (state==ON) & oe[c]. Turn-off is combinational with zero latency. q_en first goes high OE_DELAY edges after the first edge at which oe was sampled high.
- q[c] = q_en[c] ? t[c] : 0.
- oe glitch during ARM (low for one cycle) restarts the full OE_DELAY count.
- g toggling while ON: q follows t with no extra latency. q_en is unaffected.
- Snapshot: on an edge with snap=1, snap_q[c] <= t[c] for all channels regardless of q_en. snap_valid=1 on the following cycle only. Back-to-back snap updates every cycle and keeps snap_valid high.
- Simultaneous g=1 and snap on the same edge: snap_q captures the current d. lat_r also captures d.
- Reset mid-ARM: the count is lost; after reset release, oe must be resampled and the full delay applies again.
- Channels are fully independent; no arbitration between channels.

Optional Feature:
TLAT_BANK_TRISTATE_EN
- Defined: q[c] is driven 'z when q_en[c]=0. The port becomes tri-state capable for shared-bus simulation, matching the legacy OE-cell semantics.
- Undefined: q[c] is driven 0 when disabled. Fully synthesizable, no tri-states.
- q_en behaviour is identical in both builds.

Decomposition:
- Package tlat_bank_pkg:
  - typedef enum oe_state_t {OE_OFF, OE_ARM, OE_ON}.
  - Function for counter width.
  - Localparam limits MAX_WIDTH=64, MAX_CHANNELS=16, MAX_OE_DELAY=255.
- Sub-module tlat_chan: one channel, containing lat_r, t, the OE FSM, q and q_en. Parameters WIDTH and OE_DELAY.
- Top module: generate-instantiates CHANNELS copies of tlat_chan and adds the snapshot register and packing.

Test Plan:
1. Reset values, then transparency and hold (WIDTH=8, ch0): rst_n=0 for 3 cycles gives all q=0, q_en=0, snap_valid=0. Release; oe0=1, d0=8'hA5, g0=1 gives q0=A5 in the same cycle once q_en0=1. Drop g0, set d0=8'h3C; q0 stays A5.
2. Turn-on delay (OE_DELAY=2): oe1 rises before edge k; q_en1=0 after edges k and k+1, q_en1=1 after edge k+2. With OE_DELAY=0: q_en1=1 after edge k.
3. Turn-off and glitch: oe1 low while ON gives q_en1=0 and q1=0 in the same cycle. A one-cycle oe1 drop during ARM restarts the delay: q_en rises 2 edges after oe returns high.
4. Snapshot: ch0=11, ch1=22 (held), ch2 transparent with d=33, ch3 disabled holding 44. snap pulse gives snap_q={44,33,22,11} and a single snap_valid pulse one cycle later.
5. Async reset mid-operation: assert rst_n between edges while ch2 is ON. q_en2 and q2 go to 0 immediately. After release with oe2 held high, q_en2 returns after OE_DELAY edges.
6. Tri-state build (TLAT_BANK_TRISTATE_EN defined): a disabled channel reads 'z and an enabled channel reads its data. Undefined build: the same disabled channel reads 0.
